rr_arb: RTL and testbench

RR_ARB -- requirements
Module: rr_arb

---
 rtl/rr_arb_pkg.sv | 16 +
 rtl/rr_prio_enc.sv | 43 ++++
 rtl/rr_arb.sv | 148 ++++++++++++++
 tb/tb_rr_arb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
// Shared definitions for the round-robin arbiter: the FSM state encoding and
// the default requester count / maximum hold length used by rr_arb.
// No ports (package).
package rr_arb_pkg;

  // Two-state arbiter FSM; encoding is fixed so state can be probed directly.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc
// Rotating priority encoder. The search begins one above ptr and wraps from
// N-1 back to 0, so the most recent winner (ptr) is the last candidate.
// Purely combinational.
// Ports:
//   req        in  [N-1:0]          request vector
//   ptr        in  [$clog2(N)-1:0]  index of the previous winner
//   winner     out [N-1:0]          one-hot winner, zero when nobody requests
//   winner_idx out [$clog2(N)-1:0]  encoded winner, zero when nobody requests
//   any        out                  at least one request is set
module rr_prio_enc
  import rr_arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Walk the N candidates in priority order; the first one found sets 'any',
  // which masks every later candidate.
  always_comb begin
    logic [IW-1:0] idx;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb.sv
// rr_arb
// Round-robin arbiter for a shared resource. In IDLE the next requester after
// the previous winner is granted; the grant is held in GRANT until the owner
// signals done, drops its request, or (optionally) holds it too long. Every
// release is followed by exactly one IDLE cycle with gnt=0.
// Optional feature: define RR_ARB_TIMEOUT_EN to compile in the hold counter
// that forcibly revokes a grant after MAX_HOLD GRANT cycles and pulses timeout.
// Ports:
//   clk     in                   rising-edge clock
//   rst     in                   asynchronous active-high reset
//   req     in  [N-1:0]          request lines, bit i is requester i
//   done    in                   owner releases the resource
//   gnt     out [N-1:0]          registered one-hot grant (or zero)
//   gnt_id  out [$clog2(N)-1:0]  encoded grant, zero when gnt is zero
//   busy    out                  FSM is in GRANT
//   timeout out                  one-cycle pulse in the IDLE cycle after a revoke
module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  // Reject configurations the encoder and hold counter are not sized for.
  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arb: N must be 2..8 and MAX_HOLD at least 1");
  end

  state_t        state, state_next;
  logic [N-1:0]  gnt_next;
  logic [IW-1:0] gnt_id_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          revoke;
  logic          release_evt;

  rr_prio_enc #(.N(N)) u_prio_enc (
    .req        (req),
    .ptr        (ptr),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt, hold_next;
  logic          timeout_q, timeout_next;

  // The counter holds the number of GRANT cycles already completed; when the
  // last allowed cycle is ending the grant is revoked at this edge.
  assign revoke = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));

  // Count only while the grant persists; any exit from GRANT clears it. The
  // timeout pulse is reserved for a revoke that no ordinary release beat.
  always_comb begin
    hold_next    = '0;
    timeout_next = 1'b0;
    if (state == GRANT && state_next == GRANT) begin
      hold_next = hold_cnt + 1'b1;
    end
    if (revoke && !done && req[gnt_id]) begin
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_next;
      timeout_q <= timeout_next;
    end
  end

  assign timeout = timeout_q;
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Any of these ends the current grant; non-owner requests are not looked at.
  assign release_evt = done | ~req[gnt_id] | revoke;

  // Next-state logic. IDLE arbitrates and loads the grant, GRANT only watches
  // for a release, so a new request arriving with done waits one IDLE cycle.
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    gnt_id_next = gnt_id;
    ptr_next    = ptr;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_next  = GRANT;
          gnt_next    = win_oh;
          gnt_id_next = win_idx;
          ptr_next    = win_idx;
        end
      end
      GRANT: begin
        if (release_evt) begin
          state_next  = IDLE;
          gnt_next    = '0;
          gnt_id_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = '0;
      end
    endcase
  end

  // State register. ptr resets to N-1 so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= IW'(N - 1);
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      gnt_id <= gnt_id_next;
      ptr    <= ptr_next;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb
// Directed scoreboard bench for rr_arb (N=4, MAX_HOLD=8). Each stimulus call
// drives req/done at the falling edge and queues the outputs expected after
// the following rising edge; an independent monitor pops and compares them.
// Reset behaviour is checked directly between clock edges.
module tb_rr_arb;

  localparam int N = 4;

  typedef struct {
    int         step;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  rr_arb #(.N(N), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic d,
                               input logic [3:0] eg, input logic [1:0] eid,
                               input logic eb, input logic eto);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    step_no++;
    e.step    = step_no;
    e.gnt     = eg;
    e.gnt_id  = eid;
    e.busy    = eb;
    e.timeout = eto;
    exp_q.push_back(e);
  endtask

  // Assert reset between edges, confirm outputs clear with no clock edge,
  // then release it on a falling edge.
  task automatic applyReset(input string tag);
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #1;
    checkOutput({tag, " gnt"},     32'(gnt),     32'h0);
    checkOutput({tag, " gnt_id"},  32'(gnt_id),  32'h0);
    checkOutput({tag, " busy"},    32'(busy),    32'h0);
    checkOutput({tag, " timeout"}, 32'(timeout), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("step%0d gnt", e.step),     32'(gnt),     32'(e.gnt));
        checkOutput($sformatf("step%0d gnt_id", e.step),  32'(gnt_id),  32'(e.gnt_id));
        checkOutput($sformatf("step%0d busy", e.step),    32'(busy),    32'(e.busy));
        checkOutput($sformatf("step%0d timeout", e.step), 32'(timeout), 32'(e.timeout));
      end
    end
  end

  // Watchdog so a broken design cannot stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    applyReset("por");

    // Single requester: grant, hold, done, one IDLE cycle, re-grant.
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    // done with no request in IDLE has no effect.
    applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    applyReset("rst2");

    // All requesting: rotation 0,1,2,3,0 with done each grant.
    applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    // Non-owner bits drop during GRANT: grant unchanged.
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    // done plus new requests: release first, arbitrate in IDLE (ptr=0 -> 2).
    applyStimulus(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Pointer wrap: move ptr to 3, then req=1001 must pick 0.
    applyStimulus(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner drop without done: release next cycle, next requester after.
    applyStimulus(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-grant while gnt=0100; ptr returns to 3 so 1111 picks 0.
    applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    applyReset("midgrant");
    applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // Owner 1 never releases: 8 GRANT cycles, revoke with timeout pulse,
    // then requester 2 is granted.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Without the timeout feature the grant is held indefinitely.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif
    applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    checkOutput("queue drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
